// File: rtl/dsp_axis_mac.sv
// dsp_axis_mac: three-stream AXI-Stream joined multiply-accumulate.
// Mode 0 emits A*B+C for every beat; mode 1 sums A*B over a packet
// (seeded with C on the first beat) and emits once on the last beat.
module dsp_axis_mac #(
    parameter int DATA_WIDTH  = 16,
    parameter int ACC_WIDTH   = 2*DATA_WIDTH+8,
    parameter int SIGNED_MODE = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] s_axis_data_a,
    input  logic [DATA_WIDTH-1:0] s_axis_data_b,
    input  logic [DATA_WIDTH-1:0] s_axis_data_c,
    input  logic                  s_axis_valid_a,
    input  logic                  s_axis_valid_b,
    input  logic                  s_axis_valid_c,
    input  logic                  s_axis_last_a,
    input  logic                  s_axis_last_b,
    input  logic                  s_axis_last_c,
    output logic                  s_axis_ready_a,
    output logic                  s_axis_ready_b,
    output logic                  s_axis_ready_c,
    input  logic                  mode,
    output logic [ACC_WIDTH-1:0]  m_axis_data,
    output logic                  m_axis_valid,
    output logic                  m_axis_last,
    input  logic                  m_axis_ready,
    output logic                  err_last
);

    localparam int PW  = 2*DATA_WIDTH;
    localparam bit SGN = (SIGNED_MODE != 0);

    logic [PW-1:0]        a_x_d, b_x_d, prod_d;
    logic [ACC_WIDTH-1:0] prod_ext_d, c_ext_d, sum_d;
    logic                 all_valid, beat_last, last_mismatch;
    logic                 out_load, s1_adv, accept, eff_mode;

    // S1 stage: extended product/addend plus per-beat control
    logic                 s1_valid_q, s1_last_q, s1_emit_q, s1_chain_q, s1_accmode_q;
    logic [ACC_WIDTH-1:0] s1_prod_q, s1_c_q;
    // packet tracking and accumulator
    logic                 mid_q, mode_q;
    logic [ACC_WIDTH-1:0] acc_q;
    // output register and sticky error
    logic                 out_valid_q, out_last_q, err_q;
    logic [ACC_WIDTH-1:0] out_data_q;

    // Operand extension and full-width product (truncating a 2W x 2W
    // multiply to 2W bits yields the exact signed or unsigned product).
    always_comb begin
        a_x_d      = {{DATA_WIDTH{SGN & s_axis_data_a[DATA_WIDTH-1]}}, s_axis_data_a};
        b_x_d      = {{DATA_WIDTH{SGN & s_axis_data_b[DATA_WIDTH-1]}}, s_axis_data_b};
        prod_d     = a_x_d * b_x_d;
        prod_ext_d = {{(ACC_WIDTH-PW){SGN & prod_d[PW-1]}}, prod_d};
        c_ext_d    = {{(ACC_WIDTH-DATA_WIDTH){SGN & s_axis_data_c[DATA_WIDTH-1]}}, s_axis_data_c};
    end

    // Handshake join, pipeline advance conditions and S1 sum
    always_comb begin
        all_valid     = s_axis_valid_a & s_axis_valid_b & s_axis_valid_c;
        beat_last     = s_axis_last_a | s_axis_last_b | s_axis_last_c;
        last_mismatch = (s_axis_last_a != s_axis_last_b) | (s_axis_last_b != s_axis_last_c);
        out_load      = !out_valid_q || m_axis_ready;
        s1_adv        = !s1_valid_q || out_load;
        accept        = all_valid && s1_adv && !reset;
        eff_mode      = mid_q ? mode_q : mode;
        sum_d         = s1_prod_q + s1_c_q + (s1_chain_q ? acc_q : '0);
    end

    assign s_axis_ready_a = accept;
    assign s_axis_ready_b = accept;
    assign s_axis_ready_c = accept;

    // S1 capture, packet/mode tracking and sticky last-mismatch flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q   <= 1'b0;
            s1_last_q    <= 1'b0;
            s1_emit_q    <= 1'b0;
            s1_chain_q   <= 1'b0;
            s1_accmode_q <= 1'b0;
            s1_prod_q    <= '0;
            s1_c_q       <= '0;
            mid_q        <= 1'b0;
            mode_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid_q <= accept;
            end
            if (accept) begin
                // Later beats of a mode-1 packet chain onto the accumulator
                // and drop C; everything else starts from C.
                s1_prod_q    <= prod_ext_d;
                s1_c_q       <= (eff_mode && mid_q) ? '0 : c_ext_d;
                s1_chain_q   <= eff_mode && mid_q;
                s1_accmode_q <= eff_mode;
                s1_emit_q    <= !eff_mode || beat_last;
                s1_last_q    <= beat_last;
                mid_q        <= !beat_last;
                if (!mid_q) begin
                    mode_q <= mode;
                end
                if (last_mismatch) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    // Accumulator update and output register load
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else if (out_load) begin
            if (s1_valid_q && s1_accmode_q) begin
                acc_q <= s1_last_q ? '0 : sum_d;
            end
            out_valid_q <= s1_valid_q && s1_emit_q;
            if (s1_valid_q && s1_emit_q) begin
                out_data_q <= sum_d;
                out_last_q <= s1_last_q;
            end
        end
    end

    assign m_axis_data  = out_data_q;
    assign m_axis_valid = out_valid_q;
    assign m_axis_last  = out_last_q;
    assign err_last     = err_q;

endmodule

// File: tb/tb_dsp_axis_mac.sv
// Testbench for dsp_axis_mac: directed scenarios plus randomized traffic
// checked against a packet-level arithmetic reference model.
module tb_dsp_axis_mac;

    localparam int DW = 16;
    localparam int AW = 2*DW+8;
    localparam logic [63:0] MASK = (64'd1 << AW) - 64'd1;

    logic          clk, rst;
    logic [DW-1:0] a, b, c;
    logic          va, vb, vc, la, lb, lc, md, mr;
    logic          ra, rb, rc, mv, ml, err;
    logic [AW-1:0] mdata;

    dsp_axis_mac #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .SIGNED_MODE(1)) dut (
        .clk(clk), .reset(rst),
        .s_axis_data_a(a), .s_axis_data_b(b), .s_axis_data_c(c),
        .s_axis_valid_a(va), .s_axis_valid_b(vb), .s_axis_valid_c(vc),
        .s_axis_last_a(la), .s_axis_last_b(lb), .s_axis_last_c(lc),
        .s_axis_ready_a(ra), .s_axis_ready_b(rb), .s_axis_ready_c(rc),
        .mode(md),
        .m_axis_data(mdata), .m_axis_valid(mv), .m_axis_last(ml), .m_axis_ready(mr),
        .err_last(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: packet-level arithmetic on 64-bit integers
    typedef struct { logic [63:0] d; logic l; } exp_t;
    exp_t   exp_q[$];
    exp_t   e;
    logic   in_pkt, pkt_mode, exp_err;
    longint acc_m;
    logic   stall_prev, prev_last;
    logic [63:0] prev_data;

    function automatic longint sx(input logic [DW-1:0] v);
        return longint'($signed(v));
    endfunction

    task automatic model_accept();
        longint p, r;
        logic   lst, m;
        exp_t   n;
        lst = la | lb | lc;
        if (!(la == lb && lb == lc)) exp_err = 1'b1;
        m = in_pkt ? pkt_mode : md;
        if (!in_pkt) pkt_mode = md;
        p = sx(a) * sx(b);
        if (!m) begin
            r = p + sx(c);
            n.d = 64'(r) & MASK; n.l = lst;
            exp_q.push_back(n);
        end else begin
            acc_m = in_pkt ? acc_m + p : sx(c) + p;
            if (lst) begin
                n.d = 64'(acc_m) & MASK; n.l = 1'b1;
                exp_q.push_back(n);
            end
        end
        in_pkt = !lst;
    endtask

    task automatic model_reset();
        exp_q.delete();
        in_pkt = 1'b0; pkt_mode = 1'b0; exp_err = 1'b0; acc_m = 0;
    endtask

    // Scoreboard: all sampling on the falling edge
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", 64'(mv), 64'd1);
                check("hold_data", 64'(mdata), prev_data);
                check("hold_last", 64'(ml), 64'(prev_last));
            end
            if (mv && mr) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 64'(mv), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", 64'(mdata), e.d);
                    check("out_last", 64'(ml), 64'(e.l));
                end
            end
            stall_prev = mv && !mr;
            prev_data  = 64'(mdata);
            prev_last  = ml;
            check("err_last", 64'(err), 64'(exp_err));
            check("ready_equal", 64'({rb, rc}), 64'({ra, ra}));
            if (!(va && vb && vc)) check("ready_join", 64'(ra), 64'd0);
            if (va && vb && vc && ra) model_accept();
        end
    end

    task automatic drive(input logic [DW-1:0] ia, ib, ic, input logic ila, ilb, ilc, imd);
        a = ia; b = ib; c = ic; la = ila; lb = ilb; lc = ilc; md = imd;
        va = 1'b1; vb = 1'b1; vc = 1'b1;
    endtask

    // Present one beat and hold it until accepted (called at posedge+1)
    task automatic beat(input logic [DW-1:0] ia, ib, ic, input logic ila, ilb, ilc, imd);
        int n;
        n = 0;
        drive(ia, ib, ic, ila, ilb, ilc, imd);
        @(negedge clk);
        while (!ra) begin
            n++;
            if (n > 200) begin
                check("accept_timeout", 64'(ra), 64'd1);
                break;
            end
            @(negedge clk);
        end
        @(posedge clk); #1;
        va = 1'b0; vb = 1'b0; vc = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    logic bp_done;
    int   held, n;
    logic [DW-1:0] ra_v, rb_v, rc_v;
    logic rl, rm, rl2, rl3;

    initial begin
        model_reset();
        stall_prev = 1'b0; prev_data = '0; prev_last = 1'b0;
        rst = 1'b1; mr = 1'b1; md = 1'b0;
        a = '0; b = '0; c = '0; la = 1'b0; lb = 1'b0; lc = 1'b0;
        va = 1'b1; vb = 1'b1; vc = 1'b1;
        repeat (2) @(posedge clk); #1;
        check("rst_valid", 64'(mv), 64'd0);
        check("rst_data", 64'(mdata), 64'd0);
        check("rst_last", 64'(ml), 64'd0);
        check("rst_ready", 64'({ra, rb, rc}), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        va = 1'b0; vb = 1'b0; vc = 1'b0;
        rst = 1'b0;
        idle(2);

        // Mode 0 basics and two-cycle latency
        beat(16'd3, 16'd4, 16'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        check("lat_s1_valid", 64'(mv), 64'd0);
        @(negedge clk);
        check("lat_out_valid", 64'(mv), 64'd1);
        check("lat_out_data", 64'(mdata), 64'd17);
        @(posedge clk); #1;
        beat(16'hFFFE, 16'd3, 16'd1, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(4);

        // Mode 1 packet: 10 + 1*4 + 2*5 + 3*6 = 42
        beat(16'd1, 16'd4, 16'd10, 1'b0, 1'b0, 1'b0, 1'b1);
        beat(16'd2, 16'd5, 16'd99, 1'b0, 1'b0, 1'b0, 1'b1);
        beat(16'd3, 16'd6, 16'd99, 1'b1, 1'b1, 1'b1, 1'b1);
        idle(4);

        // Join: C stream missing for three cycles
        drive(16'd7, 16'd8, 16'd9, 1'b1, 1'b1, 1'b1, 1'b0);
        vc = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("join_wait_ready", 64'(ra), 64'd0);
        end
        @(posedge clk); #1;
        vc = 1'b1;
        @(negedge clk);
        check("join_accept", 64'(ra), 64'd1);
        @(posedge clk); #1;
        va = 1'b0; vb = 1'b0; vc = 1'b0;
        idle(4);

        // Stream of 5 with a stall window
        bp_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 5; i++)
                    beat(16'(i + 1), 16'(i + 2), 16'(i * 3), 1'b1, 1'b1, 1'b1, 1'b0);
                bp_done = 1'b1;
            end
            begin
                @(posedge clk); #1;
                mr = 1'b0;
                repeat (4) @(posedge clk);
                #1;
                mr = 1'b1;
            end
        join
        idle(6);

        // Capacity: with output stalled only two beats can be held
        mr = 1'b0;
        drive(16'd5, 16'd5, 16'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        held = 0;
        repeat (8) begin
            @(negedge clk);
            if (ra) held++;
        end
        check("held_beats", 64'(held), 64'd2);
        check("ready_stalled", 64'(ra), 64'd0);
        @(posedge clk); #1;
        va = 1'b0; vb = 1'b0; vc = 1'b0;
        mr = 1'b1;
        idle(5);

        // Last mismatch closes the packet and sets the sticky flag
        beat(16'd1, 16'd1, 16'd2, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(3);
        check("err_set", 64'(err), 64'd1);
        beat(16'd2, 16'd3, 16'd4, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(3);
        check("err_sticky", 64'(err), 64'd1);

        // Reset mid-packet, then a fresh single-beat packet: 1 + 2*2 = 5
        beat(16'd1, 16'd1, 16'd1, 1'b0, 1'b0, 1'b0, 1'b1);
        beat(16'd2, 16'd2, 16'd2, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(16'd2, 16'd2, 16'd1, 1'b1, 1'b1, 1'b1, 1'b1);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 64'(mv), 64'd0);
        check("mid_rst_data", 64'(mdata), 64'd0);
        check("mid_rst_last", 64'(ml), 64'd0);
        check("mid_rst_ready", 64'(ra), 64'd0);
        check("mid_rst_err", 64'(err), 64'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 64'(ra), 64'd1);
        @(posedge clk); #1;
        va = 1'b0; vb = 1'b0; vc = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("post_rst_data", 64'(mdata), 64'd5);
        @(posedge clk); #1;

        // Randomized traffic with random backpressure and mode changes
        bp_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    ra_v = 16'($urandom);
                    rb_v = 16'($urandom);
                    rc_v = 16'($urandom);
                    if ($urandom_range(0, 7) == 0) ra_v = 16'h8000;
                    if ($urandom_range(0, 7) == 0) rb_v = 16'hFFFF;
                    if ($urandom_range(0, 7) == 0) rc_v = 16'h7FFF;
                    rl  = ($urandom_range(0, 3) == 0) || (i == 299);
                    rl2 = rl; rl3 = rl;
                    if ($urandom_range(0, 19) == 0) rl2 = ~rl;
                    if ($urandom_range(0, 19) == 0) rl3 = ~rl;
                    rm = 1'($urandom_range(0, 1));
                    beat(ra_v, rb_v, rc_v, rl, rl2, rl3, rm);
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk); #1;
                    end
                end
                bp_done = 1'b1;
            end
            begin
                while (!bp_done) begin
                    @(posedge clk); #1;
                    mr = ($urandom_range(0, 3) != 0);
                end
                mr = 1'b1;
            end
        join

        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        idle(3);
        @(negedge clk);
        check("idle_valid", 64'(mv), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
